// File: rtl/flappy_pkg.sv
// Shared constants and types for the 160x120 VGA plotting path.
package flappy_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    COLS  = 2'd2,
    DOT   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame tick: one-cycle pulse every FRAME_CYCLES clocks.
module frame_tick_gen #(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int CNT_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  // Count 0..FRAME_CYCLES-1 and register the wrap as the tick pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_W'(FRAME_CYCLES - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/plot_scheduler.sv
// Frame scheduler owning the single pixel-write port of the VGA adapter.
// Per frame: optional full-screen erase, then columns phase, then dot phase.
// Optional erase sweep is built when PLOT_SCHED_ERASE_EN is defined.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a pending frame tick, both readies low
// ERASE | raster sweep writing ERASE_COLOUR, one pixel per cycle
// COLS  | col_ready high, ends on col_last beat or phase timeout
// DOT   | dot_ready high, ends on dot_last beat or phase timeout
module plot_scheduler
  import flappy_pkg::*;
#(
  parameter int                  FRAME_CYCLES  = 833333,
  parameter int                  PHASE_TIMEOUT = 4096,
  parameter logic [COLOUR_W-1:0] ERASE_COLOUR  = 3'b000
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                frame_start,
  input  logic                col_valid,
  input  logic [X_W-1:0]      col_x,
  input  logic [Y_W-1:0]      col_y,
  input  logic [COLOUR_W-1:0] col_colour,
  input  logic                col_last,
  output logic                col_ready,
  input  logic                dot_valid,
  input  logic [X_W-1:0]      dot_x,
  input  logic [Y_W-1:0]      dot_y,
  input  logic [COLOUR_W-1:0] dot_colour,
  input  logic                dot_last,
  output logic                dot_ready,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                overrun,
  output logic                timeout
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_COLS = COLS;
  localparam logic [1:0] S_DOT  = DOT;
`ifdef PLOT_SCHED_ERASE_EN
  localparam logic [1:0] S_ERASE = ERASE;
  localparam logic [1:0] S_FIRST = S_ERASE;
`else
  localparam logic [1:0] S_FIRST = S_COLS;
  // Without the sweep the erase colour has no consumer.
  localparam logic [COLOUR_W-1:0] unused_erase_colour = ERASE_COLOUR;
`endif

  localparam int PT_W = $clog2(PHASE_TIMEOUT + 1);
  localparam logic [PT_W-1:0] PT_LAST = PT_W'(PHASE_TIMEOUT - 1);

  logic [1:0]      state;
  logic            pending;
  logic            tick;
  logic [PT_W-1:0] ptimer;
`ifdef PLOT_SCHED_ERASE_EN
  logic [X_W-1:0]  ex;
  logic [Y_W-1:0]  ey;
`endif

  frame_tick_gen #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_tick (
    .clk   (clk),
    .resetn(resetn),
    .tick  (tick)
  );

  // Readies and frame_start decode from state only, never from valid.
  assign col_ready   = (state == S_COLS);
  assign dot_ready   = (state == S_DOT);
  assign frame_start = (state == S_IDLE) && pending;

  // Phase sequencing, pending/overrun/timeout bookkeeping and the registered pixel port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      pending <= 1'b0;
      ptimer  <= '0;
`ifdef PLOT_SCHED_ERASE_EN
      ex      <= '0;
      ey      <= '0;
`endif
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      plot <= 1'b0;

      // A tick mid-frame is remembered once; extra ticks collapse into it.
      if (tick) begin
        pending <= 1'b1;
        if (state != S_IDLE) overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (pending) begin
            pending <= 1'b0;
            ptimer  <= '0;
            state   <= S_FIRST;
          end
        end
`ifdef PLOT_SCHED_ERASE_EN
        S_ERASE: begin
          x      <= ex;
          y      <= ey;
          colour <= ERASE_COLOUR;
          plot   <= 1'b1;
          if (ex == X_W'(SCREEN_W - 1)) begin
            ex <= '0;
            if (ey == Y_W'(SCREEN_H - 1)) begin
              ey     <= '0;
              ptimer <= '0;
              state  <= S_COLS;
            end else begin
              ey <= ey + 1'b1;
            end
          end else begin
            ex <= ex + 1'b1;
          end
        end
`endif
        S_COLS: begin
          ptimer <= ptimer + 1'b1;
          if (col_valid) begin
            x      <= col_x;
            y      <= col_y;
            colour <= col_colour;
            plot   <= 1'b1;
          end
          // A last beat wins over a timeout landing in the same cycle.
          if (col_valid && col_last) begin
            ptimer <= '0;
            state  <= S_DOT;
          end else if (ptimer == PT_LAST) begin
            ptimer  <= '0;
            timeout <= 1'b1;
            state   <= S_DOT;
          end
        end
        S_DOT: begin
          ptimer <= ptimer + 1'b1;
          if (dot_valid) begin
            x      <= dot_x;
            y      <= dot_y;
            colour <= dot_colour;
            plot   <= 1'b1;
          end
          if (dot_valid && dot_last) begin
            ptimer <= '0;
            state  <= S_IDLE;
          end else if (ptimer == PT_LAST) begin
            ptimer  <= '0;
            timeout <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_scheduler.sv
// Directed bench for plot_scheduler: vector tables for the beat phases plus
// hand sequences for timeout, async reset, overrun and (when built) erase.
module tb_plot_scheduler;
  import flappy_pkg::*;

`ifdef PLOT_SCHED_ERASE_EN
  localparam int FC_A = 20000;
`else
  localparam int FC_A = 64;
`endif
  localparam int FC_B = 64;

  logic clk = 1'b0;
  logic resetn_a = 1'b0;
  logic resetn_b = 1'b0;

  logic       col_valid = 1'b0, col_last = 1'b0, dot_valid = 1'b0, dot_last = 1'b0;
  logic [7:0] col_x = '0, dot_x = '0;
  logic [6:0] col_y = '0, dot_y = '0;
  logic [2:0] col_colour = '0, dot_colour = '0;

  logic       frame_start_a, col_ready_a, dot_ready_a, plot_a, overrun_a, timeout_a;
  logic [7:0] x_a;
  logic [6:0] y_a;
  logic [2:0] colour_a;
  logic       frame_start_b, col_ready_b, dot_ready_b, plot_b, overrun_b, timeout_b;
  logic [7:0] x_b;
  logic [6:0] y_b;
  logic [2:0] colour_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  plot_scheduler #(.FRAME_CYCLES(FC_A), .PHASE_TIMEOUT(16), .ERASE_COLOUR(3'b000)) dut_a (
    .clk(clk), .resetn(resetn_a), .frame_start(frame_start_a),
    .col_valid(col_valid), .col_x(col_x), .col_y(col_y), .col_colour(col_colour),
    .col_last(col_last), .col_ready(col_ready_a),
    .dot_valid(dot_valid), .dot_x(dot_x), .dot_y(dot_y), .dot_colour(dot_colour),
    .dot_last(dot_last), .dot_ready(dot_ready_a),
    .x(x_a), .y(y_a), .colour(colour_a), .plot(plot_a),
    .overrun(overrun_a), .timeout(timeout_a)
  );

  plot_scheduler #(.FRAME_CYCLES(FC_B)) dut_b (
    .clk(clk), .resetn(resetn_b), .frame_start(frame_start_b),
    .col_valid(col_valid), .col_x(col_x), .col_y(col_y), .col_colour(col_colour),
    .col_last(col_last), .col_ready(col_ready_b),
    .dot_valid(dot_valid), .dot_x(dot_x), .dot_y(dot_y), .dot_colour(dot_colour),
    .dot_last(dot_last), .dot_ready(dot_ready_b),
    .x(x_b), .y(y_b), .colour(colour_b), .plot(plot_b),
    .overrun(overrun_b), .timeout(timeout_b)
  );

  typedef struct {
    logic       cv;
    logic [7:0] cx;
    logic [6:0] cy;
    logic [2:0] cc;
    logic       cl;
    logic       dv;
    logic [7:0] dx;
    logic [6:0] dy;
    logic [2:0] dc;
    logic       dl;
    logic       e_cr;
    logic       e_dr;
    logic       e_plot;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    col_valid = 1'b0; col_last = 1'b0; dot_valid = 1'b0; dot_last = 1'b0;
  endtask

  task automatic drive_col(input logic [7:0] cx, input logic [6:0] cy, input logic [2:0] cc, input logic cl);
    col_valid = 1'b1; col_x = cx; col_y = cy; col_colour = cc; col_last = cl;
  endtask

  task automatic drive_dot(input logic [7:0] dx, input logic [6:0] dy, input logic [2:0] dc, input logic dl);
    dot_valid = 1'b1; dot_x = dx; dot_y = dy; dot_colour = dc; dot_last = dl;
  endtask

  task automatic wait_fs(input bit use_b, input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      step();
      if ((use_b ? frame_start_b : frame_start_a) === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL wait_frame_start: no pulse within %0d cycles", limit);
    end
  endtask

  // First row is applied in the cycle after frame_start (first COLS cycle).
  task automatic run_table(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      step();
      chk($sformatf("%s[%0d].col_ready", tag, i), col_ready_a, vecs[i].e_cr);
      chk($sformatf("%s[%0d].dot_ready", tag, i), dot_ready_a, vecs[i].e_dr);
      chk($sformatf("%s[%0d].plot", tag, i), plot_a, vecs[i].e_plot);
      chk($sformatf("%s[%0d].x", tag, i), x_a, vecs[i].e_x);
      chk($sformatf("%s[%0d].y", tag, i), y_a, vecs[i].e_y);
      chk($sformatf("%s[%0d].colour", tag, i), colour_a, vecs[i].e_c);
      col_valid = vecs[i].cv; col_x = vecs[i].cx; col_y = vecs[i].cy;
      col_colour = vecs[i].cc; col_last = vecs[i].cl;
      dot_valid = vecs[i].dv; dot_x = vecs[i].dx; dot_y = vecs[i].dy;
      dot_colour = vecs[i].dc; dot_last = vecs[i].dl;
    end
    idle_inputs();
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".frame_start"}, frame_start_a, 0);
    chk({tag, ".col_ready"}, col_ready_a, 0);
    chk({tag, ".dot_ready"}, dot_ready_a, 0);
    chk({tag, ".plot"}, plot_a, 0);
    chk({tag, ".x"}, x_a, 0);
    chk({tag, ".y"}, y_a, 0);
    chk({tag, ".colour"}, colour_a, 0);
    chk({tag, ".overrun"}, overrun_a, 0);
    chk({tag, ".timeout"}, timeout_a, 0);
  endtask

  initial begin
    int n, npl, ncr, nfs, gaps, bad;
    bit seen;

    // Frame 1: three col beats then two dot beats.
    //          cv cx  cy cc cl  dv dx  dy dc dl  cr dr pl  x   y  c
    vecs[0]  = '{1, 10, 20, 1, 0,  0, 0,  0, 0, 0,  1, 0, 0,  0,  0, 0};
    vecs[1]  = '{1, 11, 21, 2, 0,  0, 0,  0, 0, 0,  1, 0, 1, 10, 20, 1};
    vecs[2]  = '{1, 12, 22, 3, 1,  0, 0,  0, 0, 0,  1, 0, 1, 11, 21, 2};
    vecs[3]  = '{0, 0,  0,  0, 0,  1, 30, 40, 5, 0,  0, 1, 1, 12, 22, 3};
    vecs[4]  = '{0, 0,  0,  0, 0,  1, 31, 41, 6, 1,  0, 1, 1, 30, 40, 5};
    vecs[5]  = '{0, 0,  0,  0, 0,  0, 0,  0, 0, 0,  0, 0, 1, 31, 41, 6};
    vecs[6]  = '{0, 0,  0,  0, 0,  0, 0,  0, 0, 0,  0, 0, 0, 31, 41, 6};
    // Frame 2: last without valid, both valid in COLS, col beats during DOT.
    vecs[7]  = '{0, 0,  0,  0, 1,  1, 50, 60, 7, 1,  1, 0, 0, 31, 41, 6};
    vecs[8]  = '{1, 1,  2,  4, 0,  1, 50, 60, 7, 1,  1, 0, 0, 31, 41, 6};
    vecs[9]  = '{0, 0,  0,  0, 0,  0, 0,  0, 0, 0,  1, 0, 1,  1,  2, 4};
    vecs[10] = '{1, 159,119,7, 1,  1, 9,  9, 1, 1,  1, 0, 0,  1,  2, 4};
    vecs[11] = '{1, 5,  5,  5, 1,  0, 0,  0, 0, 0,  0, 1, 1,159,119, 7};
    vecs[12] = '{1, 5,  5,  5, 1,  1, 0,  0, 2, 0,  0, 1, 0,159,119, 7};
    vecs[13] = '{0, 0,  0,  0, 0,  1, 80, 60, 3, 1,  0, 1, 1,  0,  0, 2};
    vecs[14] = '{0, 0,  0,  0, 0,  0, 0,  0, 0, 0,  0, 0, 1, 80, 60, 3};
    vecs[15] = '{0, 0,  0,  0, 0,  0, 0,  0, 0, 0,  0, 0, 0, 80, 60, 3};

    step();
    step();
    chk_reset_a("reset");
    resetn_a = 1'b1;

`ifdef PLOT_SCHED_ERASE_EN
    wait_fs(0, FC_A + 100, n);
    chk("erase.frame_start_cycle", n, FC_A + 1);
    npl = 0; gaps = 0; bad = 0; seen = 1'b0;
    for (int i = 0; i < 19300 && !seen; i++) begin
      step();
      if (plot_a) begin
        if (npl == 0) begin
          chk("erase.first_x", x_a, 0);
          chk("erase.first_y", y_a, 0);
        end
        if (colour_a !== 3'b000) bad++;
        npl++;
      end else if (npl != 0) begin
        gaps++;
      end
      if (dot_ready_a) bad++;
      if (col_ready_a) begin
        seen = 1'b1;
        chk("erase.last_plot", plot_a, 1);
        chk("erase.last_x", x_a, 159);
        chk("erase.last_y", y_a, 119);
      end
    end
    chk("erase.col_ready_seen", seen, 1);
    chk("erase.plot_count", npl, 19200);
    chk("erase.gaps", gaps, 0);
    chk("erase.bad_colour_or_ready", bad, 0);
    step();
    chk("erase.after_plot", plot_a, 0);
    chk("erase.after_col_ready", col_ready_a, 1);
`else
    // Frame 1: first frame_start FRAME_CYCLES+1 cycles after release.
    wait_fs(0, FC_A + 10, n);
    chk("f1.frame_start_cycle", n, FC_A + 1);
    run_table(0, 6, "f1");
    chk("f1.timeout", timeout_a, 0);

    wait_fs(0, 2 * FC_A, n);
    run_table(7, 15, "f2");

    // Frame 3: col_valid held without col_last; phase ends by timeout.
    wait_fs(0, 2 * FC_A, n);
    npl = 0; ncr = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (col_ready_a) ncr++;
      if (plot_a) begin
        chk($sformatf("to.x[%0d]", npl), x_a, 100 + npl);
        npl++;
      end
      if (i == 15) chk("to.timeout_before", timeout_a, 0);
      if (i == 16) begin
        chk("to.dot_ready", dot_ready_a, 1);
        chk("to.timeout_after", timeout_a, 1);
      end
      drive_col(8'(100 + i), 7'(i), 3'(i), 1'b0);
    end
    chk("to.col_ready_cycles", ncr, 16);
    chk("to.plot_count", npl, 16);
    col_valid = 1'b0;
    drive_dot(8'd77, 7'd66, 3'd5, 1'b1);
    step();
    chk("to.dot_plot", plot_a, 1);
    chk("to.dot_x", x_a, 77);
    chk("to.back_idle", col_ready_a | dot_ready_a, 0);
    idle_inputs();
    chk("to.overrun", overrun_a, 0);

    // Frame 4: async reset during COLS after two beats.
    wait_fs(0, 2 * FC_A, n);
    step();
    drive_col(8'd7, 7'd8, 3'd1, 1'b0);
    step();
    drive_col(8'd9, 7'd10, 3'd2, 1'b0);
    step();
    chk("rst.pre_plot", plot_a, 1);
    chk("rst.pre_x", x_a, 9);
    idle_inputs();
    #2 resetn_a = 1'b0;
    #1 chk_reset_a("rst.async");
    step();
    step();
    resetn_a = 1'b1;
    wait_fs(0, FC_A + 10, n);
    chk("rst.restart_cycle", n, FC_A + 1);
    step();
    chk("rst.restart_col_ready", col_ready_a, 1);

    // Overrun on the second instance: dot requester stalls through two ticks.
    step();
    resetn_b = 1'b1;
    wait_fs(1, FC_B + 10, n);
    chk("ovr.frame_start_cycle", n, FC_B + 1);
    step();
    chk("ovr.col_ready", col_ready_b, 1);
    drive_col(8'd3, 7'd4, 3'd5, 1'b1);
    step();
    chk("ovr.dot_ready", dot_ready_b, 1);
    chk("ovr.col_plot", plot_b, 1);
    chk("ovr.overrun_early", overrun_b, 0);
    idle_inputs();
    nfs = 0;
    for (int i = 0; i < 140; i++) begin
      step();
      if (frame_start_b) nfs++;
    end
    chk("ovr.fs_during_stall", nfs, 0);
    chk("ovr.overrun", overrun_b, 1);
    chk("ovr.still_dot", dot_ready_b, 1);
    chk("ovr.timeout", timeout_b, 0);
    drive_dot(8'd20, 7'd30, 3'd4, 1'b1);
    step();
    idle_inputs();
    chk("ovr.fs_on_idle", frame_start_b, 1);
    chk("ovr.idle_readies", col_ready_b | dot_ready_b, 0);
    chk("ovr.dot_plot", plot_b, 1);
    chk("ovr.dot_x", x_b, 20);
    step();
    chk("ovr.fs_single", frame_start_b, 0);
    chk("ovr.next_col_ready", col_ready_b, 1);
    nfs = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (frame_start_b) nfs++;
    end
    chk("ovr.no_extra_fs", nfs, 0);
    chk("ovr.overrun_sticky", overrun_b, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
